// File: rtl/pipe_stall_ctrl_pkg.sv
// pipe_stall_ctrl_pkg: stall vector encodings and flush sequencer states
package pipe_stall_ctrl_pkg;
  localparam int STALL_W = 6;
  localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_IF   = 6'b000011;
  localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
  localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;
  localparam logic [STALL_W-1:0] STALL_ALL  = 6'b111111;
  typedef enum logic [1:0] {ST_RUN, ST_FLUSH_WAIT, ST_FLUSH} state_e;
  function automatic logic [STALL_W-1:0] stall_prio(input logic m, e, d, i);
    return m ? STALL_MEM : e ? STALL_EX : d ? STALL_ID : i ? STALL_IF : STALL_NONE;
  endfunction
endpackage

// File: rtl/pipe_stall_ctrl_watchdog.sv
// stall_watchdog: wrapping stall cycle counter plus sticky consecutive-stall timeout
module stall_watchdog #(
  parameter int MAX_STALL = 256,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall0,
  output logic [CNT_W-1:0] stall_total,
  output logic             stall_timeout
);
  localparam int W = $clog2(MAX_STALL + 1);
  localparam logic [W-1:0] MAX = W'(MAX_STALL);
  logic [CNT_W-1:0] total_q, total_d;
  logic [W-1:0] run_q, run_d;
  logic to_q, to_d;
  always_comb begin
    total_d = total_q + CNT_W'(stall0);
    run_d   = !stall0 ? '0 : (run_q == MAX) ? MAX : run_q + 1'b1;
    to_d    = to_q | (run_d == MAX);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      total_q <= '0;
      run_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      total_q <= total_d;
      run_q   <= run_d;
      to_q    <= to_d;
    end
  end
  assign stall_total   = total_q;
  assign stall_timeout = to_q;
endmodule

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: merges pipeline stall requests and sequences redirect flushes
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int AW        = 32,
  parameter int MAX_STALL = 256,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stallreq_if,
  input  logic             stallreq_id,
  input  logic             stallreq_ex,
  input  logic             stallreq_mem,
  input  logic             flush_req,
  input  logic [AW-1:0]    flush_pc,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [AW-1:0]    new_pc,
  output logic [CNT_W-1:0] stall_total,
  output logic             stall_timeout
);
  state_e state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic take;
  always_comb begin
    take    = (state_q == ST_RUN) && flush_req;
    pc_d    = take ? flush_pc : pc_q;
    state_d = state_q;
    if (state_q == ST_RUN && flush_req)
      state_d = stallreq_mem ? ST_FLUSH_WAIT : ST_FLUSH;
    else if (state_q == ST_FLUSH_WAIT && !stallreq_mem)
      state_d = ST_FLUSH;
    else if (state_q == ST_FLUSH)
      state_d = ST_RUN;
    stall  = (state_q == ST_FLUSH) ? STALL_NONE :
             (state_q == ST_FLUSH_WAIT || take) ? STALL_ALL :
             stall_prio(stallreq_mem, stallreq_ex, stallreq_id, stallreq_if);
    flush  = (state_q == ST_FLUSH);
    new_pc = flush ? pc_q : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end
  stall_watchdog #(.MAX_STALL(MAX_STALL), .CNT_W(CNT_W)) u_wdog (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall0       (stall[0]),
    .stall_total  (stall_total),
    .stall_timeout(stall_timeout)
  );
endmodule
